// File: rtl/slot_round_robin_scheduler.sv
// -----------------------------------------------------------------------------
// slot_round_robin_scheduler
//
// Purpose:
//   Time-slot scheduler that shares one counter-driven datapath between
//   NUM_REQ requesters. Grants are one-hot and round-robin. Each grant lasts
//   at most SLOT_LEN cycles. An optional guard gap of GAP_CYCLES idle cycles
//   follows every grant.
//
// Ports:
//   sys_clk       in   single system clock, rising edge
//   rst           in   synchronous active-high reset
//   req[N]        in   level request per requester
//   done[N]       in   release pulse per requester (grantee bit only)
//   grant[N]      out  registered one-hot grant (or all zero)
//   grant_id[L]   out  registered index of current / last grantee
//   busy          out  high whenever the FSM is not in IDLE
//   slot_expired  out  one-cycle pulse when a grant ends by timeout
//
// Optional feature (macro SLOT_SCHED_STATS_EN):
//   grant_count[N*CW]  out  per-requester saturating grant-start counters
//   expired_count[CW]  out  saturating count of slot_expired pulses
//
// Handshake:
//   req is a level. A requester raises it and holds it until it is granted
//   or decides to abandon the request. While granted, the requester either
//   pulses done for one cycle to release, or drops req to withdraw. If it
//   does neither, the slot times out after SLOT_LEN cycles. Arbitration
//   happens only in IDLE. Activity on non-granted bits is ignored in every
//   state.
//
// The FSM state is held in state_q (type state_e). busy reflects it
// directly.
// -----------------------------------------------------------------------------
module slot_round_robin_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int SLOT_LEN      = 16,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          slot_expired
`ifdef SLOT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*COUNTER_WIDTH-1:0] grant_count,
  output logic [COUNTER_WIDTH-1:0]         expired_count
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW   = COUNTER_WIDTH;

  // Terminal counts. With no gap the GAP state is never entered, so its
  // compare value is unused.
  localparam logic [CW-1:0]   SLOT_LAST = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0]   GAP_LAST  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [ID_W-1:0] ID_RESET  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  // grant_id_q also serves as last_id, the round-robin pointer. The two
  // values are identical at all times, so one register carries both.
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CW-1:0]     slot_cnt_q, slot_cnt_d;
  logic [CW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              slot_expired_q, slot_expired_d;

  // ---------------------------------------------------------------------------
  // Round-robin winner search. Start one past the last grantee and wrap
  // modulo NUM_REQ, so the requester just served has the lowest priority.
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] winner;
  logic            winner_found;

  always_comb begin
    int cand;
    winner       = grant_id_q;
    winner_found = 1'b0;
    cand         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(grant_id_q) + i) % NUM_REQ;
      if (!winner_found && req[ID_W'(cand)]) begin
        winner_found = 1'b1;
        winner       = ID_W'(cand);
      end
    end
  end

  // A grant starts on any IDLE cycle that has a pending request.
  logic grant_start;
  assign grant_start = (state_q == ST_IDLE) && (|req);

  // End-of-grant qualifiers. They are only meaningful in GRANT.
  logic rel_done, rel_withdraw, slot_timeout, grant_end;
  assign rel_done     = done[grant_id_q];
  assign rel_withdraw = ~req[grant_id_q];
  assign slot_timeout = (slot_cnt_q == SLOT_LAST);
  assign grant_end    = rel_done | rel_withdraw | slot_timeout;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    grant_id_d     = grant_id_q;
    slot_cnt_d     = slot_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    slot_expired_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_start) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          grant_id_d      = winner;
          slot_cnt_d      = '0;
          state_d         = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (grant_end) begin
          grant_d   = '0;
          gap_cnt_d = '0;
          // A release in the same cycle as the timeout wins. Only a pure
          // timeout is reported.
          slot_expired_d = slot_timeout & ~rel_done & ~rel_withdraw;
          state_d        = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        grant_d = '0;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      grant_id_q     <= ID_RESET;
      slot_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      slot_expired_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      grant_id_q     <= grant_id_d;
      slot_cnt_q     <= slot_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      slot_expired_q <= slot_expired_d;
    end
  end

  assign grant        = grant_q;
  assign grant_id     = grant_id_q;
  assign busy         = (state_q != ST_IDLE);
  assign slot_expired = slot_expired_q;

`ifdef SLOT_SCHED_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters. Each count is updated on the same edge
  // that registers the event it counts.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ*CW-1:0] grant_count_q, grant_count_d;
  logic [CW-1:0]         expired_count_q, expired_count_d;

  always_comb begin
    grant_count_d   = grant_count_q;
    expired_count_d = expired_count_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_start && (winner == ID_W'(i)) &&
          (grant_count_q[i*CW +: CW] != {CW{1'b1}})) begin
        grant_count_d[i*CW +: CW] = grant_count_q[i*CW +: CW] + 1'b1;
      end
    end
    if (slot_expired_d && (expired_count_q != {CW{1'b1}})) begin
      expired_count_d = expired_count_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      grant_count_q   <= '0;
      expired_count_q <= '0;
    end else begin
      grant_count_q   <= grant_count_d;
      expired_count_q <= expired_count_d;
    end
  end

  assign grant_count   = grant_count_q;
  assign expired_count = expired_count_q;
`endif

endmodule

// File: tb/tb_slot_round_robin_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for slot_round_robin_scheduler.
//
// dut_a: NUM_REQ=4, SLOT_LEN=16, GAP_CYCLES=1
// dut_b: NUM_REQ=4, SLOT_LEN=4,  GAP_CYCLES=0 (stats checked when
//        SLOT_SCHED_STATS_EN is defined)
//
// Inputs are driven 1 ns after the rising edge. Outputs are sampled at the
// same point, so every check sees the state registered by the preceding edge.
// -----------------------------------------------------------------------------
module tb_slot_round_robin_scheduler;

  localparam int N  = 4;
  localparam int CW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, rst_b;
  logic [N-1:0] req_a, done_a, req_b, done_b;
  logic [N-1:0] grant_a, grant_b;
  logic [1:0]   grant_id_a, grant_id_b;
  logic         busy_a, busy_b, slot_expired_a, slot_expired_b;
`ifdef SLOT_SCHED_STATS_EN
  logic [N*CW-1:0] grant_count_a, grant_count_b;
  logic [CW-1:0]   expired_count_a, expired_count_b;
`endif

  slot_round_robin_scheduler #(
    .NUM_REQ(N), .COUNTER_WIDTH(CW), .SLOT_LEN(16), .GAP_CYCLES(1)
  ) dut_a (
    .sys_clk(clk), .rst(rst_a), .req(req_a), .done(done_a),
    .grant(grant_a), .grant_id(grant_id_a), .busy(busy_a),
    .slot_expired(slot_expired_a)
`ifdef SLOT_SCHED_STATS_EN
    , .grant_count(grant_count_a), .expired_count(expired_count_a)
`endif
  );

  slot_round_robin_scheduler #(
    .NUM_REQ(N), .COUNTER_WIDTH(CW), .SLOT_LEN(4), .GAP_CYCLES(0)
  ) dut_b (
    .sys_clk(clk), .rst(rst_b), .req(req_b), .done(done_b),
    .grant(grant_b), .grant_id(grant_id_b), .busy(busy_b),
    .slot_expired(slot_expired_b)
`ifdef SLOT_SCHED_STATS_EN
    , .grant_count(grant_count_b), .expired_count(expired_count_b)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [N-1:0] exp_q[$];
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_a();
    req_a  = '0;
    done_a = '0;
    rst_a  = 1'b1;
    cyc();
    rst_a  = 1'b0;
  endtask

  // Bounded wait for a grant to appear. An expired bound shows up as a
  // failed comparison.
  task automatic wait_grant_a(input string tag);
    int n = 0;
    while (grant_a == '0 && n < 20) begin
      cyc();
      n++;
    end
    check(tag, 32'(grant_a != '0), 32'd1);
  endtask

  task automatic wait_grant_b(input string tag);
    int n = 0;
    while (grant_b == '0 && n < 20) begin
      cyc();
      n++;
    end
    check(tag, 32'(grant_b != '0), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [N-1:0] g;
    logic [N-1:0] e;

    rst_a = 1'b1; rst_b = 1'b1;
    req_a = '0; done_a = '0; req_b = '0; done_b = '0;
    cyc();
    cyc();

    // Reset state
    check("rst_grant",    32'(grant_a), 32'd0);
    check("rst_grant_id", 32'(grant_id_a), 32'd3);
    check("rst_busy",     32'(busy_a), 32'd0);
    check("rst_expired",  32'(slot_expired_a), 32'd0);
    rst_a = 1'b0;

    // Single requester: full slot, timeout, gap, re-grant.
    req_a = 4'b0001;
    cyc();
    check("t1_grant_rise", 32'(grant_a), 32'h1);
    check("t1_grant_id",   32'(grant_id_a), 32'd0);
    check("t1_busy",       32'(busy_a), 32'd1);
    for (int i = 1; i < 16; i++) begin
      cyc();
      check("t1_hold",    32'(grant_a), 32'h1);
      check("t1_noexp",   32'(slot_expired_a), 32'd0);
    end
    cyc();
    check("t1_drop",       32'(grant_a), 32'd0);
    check("t1_expired",    32'(slot_expired_a), 32'd1);
    check("t1_gap_busy",   32'(busy_a), 32'd1);
    check("t1_id_kept",    32'(grant_id_a), 32'd0);
    cyc();
    check("t1_pulse_once", 32'(slot_expired_a), 32'd0);
    check("t1_idle_grant", 32'(grant_a), 32'd0);
    check("t1_idle_busy",  32'(busy_a), 32'd0);
    cyc();
    check("t1_regrant",    32'(grant_a), 32'h1);

    // All request, each grantee releases with done on its 3rd cycle.
    do_reset_a();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant_a("t2_wait");
      e = exp_q.pop_front();
      check("t2_order", 32'(grant_a), 32'(e));
      g = grant_a;
      cyc();
      check("t2_hold2", 32'(grant_a), 32'(g));
      cyc();
      check("t2_hold3", 32'(grant_a), 32'(g));
      done_a = g;
      cyc();
      done_a = '0;
      check("t2_release", 32'(grant_a), 32'd0);
      check("t2_noexp",   32'(slot_expired_a), 32'd0);
    end
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Withdrawal by requester 2 in its 5th cycle. A done on a non-granted
    // bit during the grant is ignored.
    do_reset_a();
    req_a = 4'b0100;
    cyc();
    check("t3_grant2", 32'(grant_a), 32'h4);
    req_a  = 4'b1111;
    done_a = 4'b0010;
    cyc();
    done_a = '0;
    check("t3_done_other_ignored", 32'(grant_a), 32'h4);
    cyc();
    check("t3_hold3", 32'(grant_a), 32'h4);
    cyc();
    check("t3_hold4", 32'(grant_a), 32'h4);
    cyc();
    check("t3_hold5", 32'(grant_a), 32'h4);
    req_a = 4'b1011;
    cyc();
    check("t3_withdraw_drop",  32'(grant_a), 32'd0);
    check("t3_withdraw_noexp", 32'(slot_expired_a), 32'd0);
    exp_q.push_back(4'b1000);
    wait_grant_a("t3_wait");
    e = exp_q.pop_front();
    check("t3_next_from_3", 32'(grant_a), 32'(e));

    // done on the last slot cycle counts as a release.
    do_reset_a();
    req_a = 4'b0001;
    cyc();
    for (int i = 1; i < 16; i++) cyc();
    check("t4_still_granted", 32'(grant_a), 32'h1);
    done_a = 4'b0001;
    cyc();
    done_a = '0;
    check("t4_drop",  32'(grant_a), 32'd0);
    check("t4_noexp", 32'(slot_expired_a), 32'd0);

    // Reset in the middle of a grant (slot_cnt == 7).
    do_reset_a();
    req_a = 4'b1111;
    cyc();
    check("t5_grant0", 32'(grant_a), 32'h1);
    for (int i = 0; i < 7; i++) cyc();
    rst_a = 1'b1;
    cyc();
    check("t5_rst_grant",    32'(grant_a), 32'd0);
    check("t5_rst_busy",     32'(busy_a), 32'd0);
    check("t5_rst_grant_id", 32'(grant_id_a), 32'd3);
    check("t5_rst_noexp",    32'(slot_expired_a), 32'd0);
    rst_a = 1'b0;
    cyc();
    check("t5_regrant", 32'(grant_a), 32'h1);
    req_a = '0;

    // No gap: timeouts alternate between two requesters with one idle
    // cycle between grants.
    rst_b = 1'b1;
    cyc();
    rst_b = 1'b0;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    req_b = 4'b0011;
    wait_grant_b("t6_wait");
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      check("t6_order", 32'(grant_b), 32'(e));
      g = grant_b;
      for (int j = 1; j < 4; j++) begin
        cyc();
        check("t6_hold", 32'(grant_b), 32'(g));
      end
      cyc();
      check("t6_drop",    32'(grant_b), 32'd0);
      check("t6_expired", 32'(slot_expired_b), 32'd1);
      check("t6_idle",    32'(busy_b), 32'd0);
      if (k == 3) begin
        req_b = '0;
      end else begin
        cyc();
        check("t6_one_idle", 32'(grant_b != '0), 32'd1);
      end
    end
    cyc();
    check("t6_stopped", 32'(grant_b), 32'd0);
`ifdef SLOT_SCHED_STATS_EN
    check("t6_grant_count",   32'(grant_count_b), 32'h0000_0202);
    check("t6_expired_count", 32'(expired_count_b), 32'd4);
`endif

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/slot_round_robin_scheduler.md
Name: slot_round_robin_scheduler

Overview:
- Time-slot scheduler that shares one counter-driven datapath resource between NUM_REQ requesters.
- Grants are round-robin and one-hot. Each grant is bounded by a slot counter of COUNTER_WIDTH bits, and an optional guard gap is inserted between grants.
- Sits in front of the shared counter/logic datapath and drives its enable; requesters see only req/done/grant.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- COUNTER_WIDTH, 8: width of the slot and gap counters.
- SLOT_LEN, 16: maximum grant length in cycles; 1 <= SLOT_LEN <= 2^COUNTER_WIDTH - 1.
- GAP_CYCLES, 1: idle cycles after each grant; 0 <= GAP_CYCLES <= 2^COUNTER_WIDTH - 1.

Ports:
- sys_clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request per requester; level, held until granted or abandoned.
- done  input  NUM_REQ  release pulse per requester; only the granted bit is honoured.
- grant  output  NUM_REQ  one-hot grant, registered.
- grant_id  output  $clog2(NUM_REQ)  index of current or last grantee, registered.
- busy  output  1  high when the state is not IDLE.
- slot_expired  output  1  one-cycle pulse when a grant ends by timeout.

Behaviour:
- Reset: sync rst on a sys_clk edge sets the following:
  - state=IDLE, grant=0, grant_id=NUM_REQ-1, busy=0, slot_expired=0.
  - slot_cnt=0, gap_cnt=0, last_id=NUM_REQ-1.
  - Reset applies in any state, mid-grant included. Grant drops at that edge and no slot_expired pulse is issued.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, the winner is the first set bit searching last_id+1, last_id+2, ... modulo NUM_REQ.
  - At the next edge: grant=onehot(winner), grant_id=winner, last_id=winner, slot_cnt=0, state=GRANT.
  - Latency: req seen in IDLE in cycle T gives grant high in T+1.
  - If req == 0, stay in IDLE.
- GRANT: slot_cnt increments each cycle. The grant ends in cycle E when any of these holds:
  - (a) done[grant_id]=1;
  - (b) req[grant_id]=0 (withdrawn);
  - (c) slot_cnt == SLOT_LEN-1 (expiry).
- Maximum grant: exactly SLOT_LEN cycles high.
- Ending the grant, at edge E+1:
  - grant=0.
  - slot_expired=1 for one cycle only if (c) holds and neither (a) nor (b) holds.
  - GAP_CYCLES>0: state=GAP, gap_cnt=0. GAP_CYCLES=0: state=IDLE.
- GAP: gap_cnt increments; when gap_cnt == GAP_CYCLES-1, next state=IDLE. grant stays 0 throughout.
- Fairness and arbitration timing:
  - The requester just served has lowest priority at the next arbitration.
  - Requests arriving during GRANT/GAP are arbitrated only in IDLE.
- Inputs during a grant:
  - done or req changes on non-granted bits have no effect.
  - done on a non-granted bit while in IDLE is ignored.
- Simultaneous done and expiry counts as release: no slot_expired pulse.
- Width rules: counters never wrap past their compare values. grant_id retains its value after the grant ends.
- Invariant: grant is 0 or one-hot in every cycle.

Optional Feature:
- Macro: SLOT_SCHED_STATS_EN.
- Defined:
  - Adds output grant_count[NUM_REQ*COUNTER_WIDTH-1:0], one COUNTER_WIDTH field per requester.
  - The field for grant_id increments at every grant start and saturates at all-ones.
  - Cleared by rst.
  - Adds output expired_count[COUNTER_WIDTH-1:0], incremented on each slot_expired pulse, saturating, cleared by rst.
- Undefined: neither port exists, no counter logic is instantiated, and all other behaviour is identical.

Test Plan:
- Single requester, NUM_REQ=4, SLOT_LEN=16, GAP_CYCLES=1:
  - Stimulus: req=0001 held, no done, after reset.
  - Response: grant=0001 one cycle after req; grant high exactly 16 cycles; slot_expired pulses in cycle 17; grant re-asserted after 1 gap plus 1 IDLE cycle.
- All request, GAP_CYCLES=1:
  - Stimulus: req=1111 held, each grantee pulses done on its 3rd grant cycle.
  - Response: grant sequence 0001, 0010, 0100, 1000, 0001; each grant lasts 3 cycles; slot_expired never asserts.
- Withdrawal:
  - Stimulus: granted requester 2 drops req in its 5th grant cycle.
  - Response: grant=0 at the next edge, no slot_expired, next winner searched from index 3.
- Simultaneous events:
  - Stimulus: done[grant_id] asserted on the cycle slot_cnt==SLOT_LEN-1; done[1] asserted while grant=0100.
  - Response: no slot_expired pulse; the done[1] pulse is ignored and grant stays 0100.
- Reset mid-grant:
  - Stimulus: rst=1 for one cycle during GRANT at slot_cnt=7.
  - Response: at that edge grant=0, busy=0, grant_id=3; with req=1111 still held, the next grant is 0001.
- GAP_CYCLES=0 and stats:
  - Stimulus: with SLOT_SCHED_STATS_EN defined, req=0011 held, no done, 4 grants.
  - Response: grants alternate 0001/0010 with exactly 1 idle cycle between them; per-requester grant_count=2 each; expired_count=4.
